// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit and receive paths: FSM state
// encodings for both directions, the default bit period and frame length.
// No ports; imported by uart_sync2 and uart_rx.
package uart_pkg;

    // 77.5 MHz system clock / 9600 baud
    localparam int CLKS_PER_BIT_DFLT = 8073;
    localparam int DATA_BITS         = 8;

    typedef enum logic [2:0] {
        s_TX_IDLE,
        s_TX_START_BIT,
        s_TX_DATA_BITS,
        s_TX_STOP_BIT,
        s_TX_CLEANUP
    } tx_state_e;

    typedef enum logic [2:0] {
        s_IDLE,
        s_RX_START_BIT,
        s_RX_DATA_BITS,
        s_RX_STOP_BIT,
        s_CLEANUP,
        s_WAIT_HIGH
    } rx_state_e;

    // Start-bit mid-point: counting 0..result from the first low sample.
    function automatic logic [15:0] half_bit_cnt(input int clks_per_bit);
        return 16'((clks_per_bit - 1) / 2);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   i_Clock  - destination clock
//   i_Rst_n  - synchronous reset, active low; both flops load RST_VAL
//   i_Async  - asynchronous input
//   o_Sync   - synchronised output (two cycles of latency)
module uart_sync2 import uart_pkg::*; #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= i_Async;
            sync_q <= meta_q;
        end
    end

    assign o_Sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver: 1 start bit (low), 8 data bits LSB first, 1 stop bit
// (high). Samples every bit at its mid-point using a free-running clock
// counter that is re-centred on the start bit.
// Ports:
//   i_Clock      - system clock, rising edge
//   i_Rst_n      - synchronous reset, active low
//   i_Rx_Serial  - asynchronous serial line, idles high
//   o_Rx_DV      - one-cycle strobe, o_Rx_Byte newly valid
//   o_Rx_Byte    - last correctly framed byte, held between strobes
//   o_Rx_Active  - high while a frame is in progress (FSM not idle)
//   o_Frame_Err  - one-cycle strobe, stop bit sampled low
//
// state          | meaning
// ---------------+-------------------------------------------------------
// s_IDLE         | line idle, counters cleared, waiting for a low level
// s_RX_START_BIT | counting to start-bit middle, re-checking the low level
// s_RX_DATA_BITS | sampling 8 data bits one bit period apart
// s_RX_STOP_BIT  | sampling the stop bit; issues DV or framing error
// s_CLEANUP      | one cycle to drop DV before returning to idle
// s_WAIT_HIGH    | framing error seen; wait for the line to return high
module uart_rx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT   // must be >= 4
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    localparam logic [15:0] HALF_BIT = half_bit_cnt(CLKS_PER_BIT);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e   state_q,  state_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [2:0]  bit_q,    bit_d;
    logic [7:0]  data_q,   data_d;
    logic [7:0]  byte_q,   byte_d;
    logic        dv_q,     dv_d;
    logic        ferr_q,   ferr_d;
    logic        active_q, active_d;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_Rx_Serial),
        .o_Sync  (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            s_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) state_d = s_RX_START_BIT;
            end
            s_RX_START_BIT: begin
                if (cnt_q == HALF_BIT) begin
                    // still low at mid-bit: a real start bit, otherwise a glitch
                    cnt_d   = '0;
                    state_d = rx_s ? s_IDLE : s_RX_DATA_BITS;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            s_RX_DATA_BITS: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d         = '0;
                    data_d[bit_q] = rx_s;
                    if (bit_q < LAST_BIT) begin
                        bit_d = bit_q + 3'd1;
                    end else begin
                        bit_d   = '0;
                        state_d = s_RX_STOP_BIT;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            s_RX_STOP_BIT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        dv_d    = 1'b1;
                        byte_d  = data_q;
                        state_d = s_CLEANUP;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = s_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            s_CLEANUP: begin
                cnt_d   = '0;
                state_d = s_IDLE;
            end
            s_WAIT_HIGH: begin
                // a held-low break yields one framing error, not repeated frames
                cnt_d = '0;
                if (rx_s) state_d = s_IDLE;
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = s_IDLE;
            end
        endcase

        active_d = (state_d != s_IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q  <= s_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
        end
    end

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Rx_Active = active_q;
    assign o_Frame_Err = ferr_q;

endmodule
